// File: rtl/intr_seq_ctrl.sv
// Interrupt sequencing controller: NMI/IRQ0-7 edge capture, level arbitration,
// CPU request/acknowledge handshake with timeout, and a nested in-service stack.
module intr_seq_ctrl #(
    parameter int NEST_DEPTH  = 4,   // 2..7, nest_cnt is 3 bits wide
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  irq_in,
    input  logic        nmi_in,
    input  logic [31:0] prio_cfg,
    input  logic        i_bit,
    input  logic        cpu_ack,
    input  logic        cpu_eoi,
    output logic        cpu_intr,
    output logic [4:0]  vt_no,
    output logic [3:0]  cur_lvl,
    output logic [2:0]  nest_cnt,
    output logic [7:0]  irq_pend,
    output logic        ack_tmo,
    output logic        eoi_err
);
    // state    | meaning
    // ST_IDLE  | no request outstanding; arbitrate pending sources each cycle
    // ST_REQ   | cpu_intr high, vector frozen, waiting for cpu_ack or timeout
    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    state_t          state_q, state_d;
    logic [7:0]      irq_q, pend_q, pend_d, irq_rise, pend_clr;
    logic            nmi_q, nmi_pend_q, nmi_pend_d, nmi_rise;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0]      req_lvl_q, req_lvl_d;
    logic [2:0]      req_id_q, req_id_d;
    logic            req_nmi_q, req_nmi_d;
    logic            cpu_intr_q, cpu_intr_d, ack_tmo_q, ack_tmo_d, eoi_err_q, eoi_err_d;
    logic [4:0]      vt_q, vt_d;
    logic [2:0]      cnt_q, cnt_d, cnt_mid;
    logic [3:0]      stk_q [NEST_DEPTH];
    logic [3:0]      stk_d [NEST_DEPTH];
    logic [3:0]      top_lvl, cand_lvl, win_lvl;
    logic [2:0]      win_id;
    logic            win_vld, win_nmi, start, ack_go, tmo_exp, pop, push;
    logic            unused_rsvd;

    assign unused_rsvd = ^{prio_cfg[31], prio_cfg[27], prio_cfg[23], prio_cfg[19],
                           prio_cfg[15], prio_cfg[11], prio_cfg[7], prio_cfg[3]};

    // Arbitration: ascending scan with >= lets the higher index win level ties
    always_comb begin
        top_lvl  = '0;
        cand_lvl = '0;
        win_vld  = 1'b0;
        win_nmi  = 1'b0;
        win_id   = '0;
        win_lvl  = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (cnt_q != 3'd0 && 3'(i) == cnt_q - 3'd1) top_lvl = stk_q[i];
        end
        for (int i = 0; i < 8; i++) begin
            cand_lvl = {1'b0, prio_cfg[4*i +: 3]};
            if (pend_q[i] && cand_lvl != 4'd0 && !i_bit && cand_lvl > top_lvl
                && cand_lvl >= win_lvl) begin
                win_vld = 1'b1;
                win_id  = 3'(i);
                win_lvl = cand_lvl;
            end
        end
        if (nmi_pend_q && top_lvl < 4'd8) begin
            win_vld = 1'b1;
            win_nmi = 1'b1;
            win_lvl = 4'd8;
        end
    end

    assign start   = (state_q == ST_IDLE) && win_vld && (cnt_q < 3'(NEST_DEPTH));
    assign ack_go  = (state_q == ST_REQ) && cpu_ack;
    assign tmo_exp = (state_q == ST_REQ) && !cpu_ack && (tmo_q == '0);

    // New edges take priority over the acknowledge clear
    always_comb begin
        irq_rise   = irq_in & ~irq_q;
        nmi_rise   = nmi_in & ~nmi_q;
        pend_clr   = (ack_go && !req_nmi_q) ? (8'd1 << req_id_q) : 8'd0;
        pend_d     = (pend_q & ~pend_clr) | irq_rise;
        nmi_pend_d = (nmi_pend_q & ~(ack_go & req_nmi_q)) | nmi_rise;
    end

    // Pop happens before push so eoi+ack replaces the top entry
    always_comb begin
        pop       = cpu_eoi && (cnt_q != 3'd0);
        push      = ack_go;
        eoi_err_d = cpu_eoi && (cnt_q == 3'd0);
        cnt_mid   = cnt_q - {2'b00, pop};
        cnt_d     = cnt_mid + {2'b00, push};
        for (int i = 0; i < NEST_DEPTH; i++) begin
            stk_d[i] = stk_q[i];
            if (push && 3'(i) == cnt_mid) stk_d[i] = req_lvl_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_REQ;
            ST_REQ:  if (ack_go || tmo_exp) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_intr_d = cpu_intr_q;
        vt_d       = vt_q;
        ack_tmo_d  = 1'b0;
        tmo_d      = tmo_q;
        req_lvl_d  = req_lvl_q;
        req_id_d   = req_id_q;
        req_nmi_d  = req_nmi_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cpu_intr_d = 1'b1;
                    vt_d       = win_nmi ? 5'd1 : 5'd2 + {2'b00, win_id};
                    req_lvl_d  = win_lvl;
                    req_id_d   = win_id;
                    req_nmi_d  = win_nmi;
                    tmo_d      = TW'(ACK_TIMEOUT - 1);
                end
            end
            ST_REQ: begin
                if (ack_go || tmo_exp) begin
                    cpu_intr_d = 1'b0;
                    vt_d       = 5'd0;
                    ack_tmo_d  = tmo_exp;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            default: begin
                cpu_intr_d = 1'b0;
                vt_d       = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q      <= '0;
            pend_q     <= '0;
            nmi_q      <= 1'b0;
            nmi_pend_q <= 1'b0;
            tmo_q      <= '0;
            req_lvl_q  <= '0;
            req_id_q   <= '0;
            req_nmi_q  <= 1'b0;
            cpu_intr_q <= 1'b0;
            vt_q       <= '0;
            ack_tmo_q  <= 1'b0;
            eoi_err_q  <= 1'b0;
            cnt_q      <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) stk_q[i] <= '0;
        end else begin
            irq_q      <= irq_in;
            pend_q     <= pend_d;
            nmi_q      <= nmi_in;
            nmi_pend_q <= nmi_pend_d;
            tmo_q      <= tmo_d;
            req_lvl_q  <= req_lvl_d;
            req_id_q   <= req_id_d;
            req_nmi_q  <= req_nmi_d;
            cpu_intr_q <= cpu_intr_d;
            vt_q       <= vt_d;
            ack_tmo_q  <= ack_tmo_d;
            eoi_err_q  <= eoi_err_d;
            cnt_q      <= cnt_d;
            for (int i = 0; i < NEST_DEPTH; i++) stk_q[i] <= stk_d[i];
        end
    end

    assign cpu_intr = cpu_intr_q;
    assign vt_no    = vt_q;
    assign cur_lvl  = top_lvl;
    assign nest_cnt = cnt_q;
    assign irq_pend = pend_q;
    assign ack_tmo  = ack_tmo_q;
    assign eoi_err  = eoi_err_q;

endmodule

// File: tb/tb_intr_seq_ctrl.sv
// Directed bench for intr_seq_ctrl: arbitration, nesting, timeout, EOI and reset.
module tb_intr_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_in;
    logic        nmi_in;
    logic [31:0] prio_cfg;
    logic        i_bit, cpu_ack, cpu_eoi;
    logic        cpu_intr, ack_tmo, eoi_err;
    logic [4:0]  vt_no;
    logic [3:0]  cur_lvl;
    logic [2:0]  nest_cnt;
    logic [7:0]  irq_pend;

    int passed = 0;
    int total  = 0;

    intr_seq_ctrl #(.NEST_DEPTH(4), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .nmi_in(nmi_in),
        .prio_cfg(prio_cfg), .i_bit(i_bit), .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi),
        .cpu_intr(cpu_intr), .vt_no(vt_no), .cur_lvl(cur_lvl), .nest_cnt(nest_cnt),
        .irq_pend(irq_pend), .ack_tmo(ack_tmo), .eoi_err(eoi_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_ack();
        cpu_ack = 1'b1;
        tick(1);
        cpu_ack = 1'b0;
    endtask

    task automatic do_eoi();
        cpu_eoi = 1'b1;
        tick(1);
        cpu_eoi = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; irq_in = '0; nmi_in = 1'b0; prio_cfg = '0;
        i_bit = 1'b0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
        tick(3);
        chk("rst_intr", cpu_intr, 0);
        chk("rst_vt",   vt_no, 0);
        chk("rst_nest", nest_cnt, 0);
        chk("rst_pend", irq_pend, 0);
        rst_n = 1'b1;
        tick(1);

        // T1: IRQ3 level 5
        prio_cfg = 32'h0000_5000;
        irq_in = 8'h08; tick(1);
        chk("t1_pend",   irq_pend, 8'h08);
        chk("t1_intr0",  cpu_intr, 0);
        irq_in = 8'h00; tick(1);
        chk("t1_intr1",  cpu_intr, 1);
        chk("t1_vt",     vt_no, 5);
        do_ack();
        chk("t1_intr_a", cpu_intr, 0);
        chk("t1_vt_a",   vt_no, 0);
        chk("t1_pend_a", irq_pend, 8'h00);
        chk("t1_lvl",    cur_lvl, 5);
        chk("t1_nest",   nest_cnt, 1);
        do_eoi();
        chk("t1_nest_e", nest_cnt, 0);
        chk("t1_lvl_e",  cur_lvl, 0);

        // T2: IRQ1 and IRQ6 both level 4, same edge
        prio_cfg = 32'h0400_5040;
        irq_in = 8'h42; tick(1);
        irq_in = 8'h00; tick(1);
        chk("t2_vt6",    vt_no, 8);
        do_ack();
        chk("t2_pend",   irq_pend, 8'h02);
        chk("t2_lvl",    cur_lvl, 4);
        tick(1);
        chk("t2_block",  cpu_intr, 0);
        do_eoi();
        chk("t2_eoi_nq", cpu_intr, 0);
        chk("t2_nest_e", nest_cnt, 0);
        tick(1);
        chk("t2_intr1",  cpu_intr, 1);
        chk("t2_vt1",    vt_no, 3);
        do_ack();
        chk("t2_lvl1",   cur_lvl, 4);
        do_eoi();

        // T3: nesting under level 5, NMI preempts, lower level waits
        prio_cfg = 32'h0400_5340;
        irq_in = 8'h08; tick(1);
        irq_in = 8'h00; tick(1);
        chk("t3_vt3",    vt_no, 5);
        do_ack();
        chk("t3_lvl5",   cur_lvl, 5);
        irq_in = 8'h04; tick(1);
        irq_in = 8'h00;
        chk("t3_pend2",  irq_pend, 8'h04);
        tick(2);
        chk("t3_noreq",  cpu_intr, 0);
        nmi_in = 1'b1; tick(1);
        nmi_in = 1'b0; tick(1);
        chk("t3_nmi",    cpu_intr, 1);
        chk("t3_nmivt",  vt_no, 1);
        do_ack();
        chk("t3_lvl8",   cur_lvl, 8);
        chk("t3_nest2",  nest_cnt, 2);
        do_eoi();
        chk("t3_lvl5b",  cur_lvl, 5);
        chk("t3_nq",     cpu_intr, 0);
        do_eoi();
        chk("t3_lvl0",   cur_lvl, 0);
        tick(1);
        chk("t3_irq2",   vt_no, 4);
        do_ack();
        chk("t3_lvl3",   cur_lvl, 3);
        nmi_in = 1'b1; tick(1);
        nmi_in = 1'b0; tick(1);
        chk("t3_nmi2",   vt_no, 1);
        cpu_ack = 1'b1; cpu_eoi = 1'b1; tick(1);
        cpu_ack = 1'b0; cpu_eoi = 1'b0;
        chk("t3_ae_nest", nest_cnt, 1);
        chk("t3_ae_lvl",  cur_lvl, 8);
        chk("t3_ae_err",  eoi_err, 0);
        do_eoi();
        chk("t3_empty",  nest_cnt, 0);

        // T4: acknowledge timeout on IRQ0 level 2
        prio_cfg = 32'h0400_5342;
        irq_in = 8'h01; tick(1);
        irq_in = 8'h00; tick(1);
        chk("t4_req",    cpu_intr, 1);
        chk("t4_vt",     vt_no, 2);
        tick(15);
        chk("t4_hold",   cpu_intr, 1);
        chk("t4_notmo",  ack_tmo, 0);
        tick(1);
        chk("t4_drop",   cpu_intr, 0);
        chk("t4_tmo",    ack_tmo, 1);
        chk("t4_pend",   irq_pend, 8'h01);
        chk("t4_vt0",    vt_no, 0);
        tick(1);
        chk("t4_tmo_p",  ack_tmo, 0);
        chk("t4_rereq",  cpu_intr, 1);
        chk("t4_vt_r",   vt_no, 2);
        do_ack();
        chk("t4_lvl",    cur_lvl, 2);
        do_eoi();

        // T5: fill stack with rising levels
        prio_cfg = 32'h0005_4321;
        for (int k = 0; k < 4; k++) begin
            irq_in = 8'(1 << k); tick(1);
            irq_in = 8'h00; tick(1);
            chk("t5_vt",   vt_no, 2 + k);
            do_ack();
            chk("t5_nest", nest_cnt, k + 1);
        end
        chk("t5_top",    cur_lvl, 4);
        irq_in = 8'h10; tick(1);
        irq_in = 8'h00; tick(2);
        chk("t5_full",   cpu_intr, 0);
        chk("t5_pend",   irq_pend, 8'h10);
        do_eoi();
        chk("t5_nest3",  nest_cnt, 3);
        chk("t5_nq",     cpu_intr, 0);
        tick(1);
        chk("t5_req4",   vt_no, 6);
        do_ack();
        chk("t5_lvl5",   cur_lvl, 5);
        for (int k = 0; k < 4; k++) do_eoi();
        chk("t5_nest0",  nest_cnt, 0);
        chk("t5_noerr",  eoi_err, 0);
        do_eoi();
        chk("t5_err",    eoi_err, 1);
        chk("t5_nest_k", nest_cnt, 0);
        tick(1);
        chk("t5_err_p",  eoi_err, 0);

        // T6: i_bit masks IRQs but not NMI; reset during REQ
        prio_cfg = 32'h7005_4321;
        i_bit = 1'b1;
        irq_in = 8'h80; tick(1);
        irq_in = 8'h00; tick(2);
        chk("t6_mask",   cpu_intr, 0);
        chk("t6_pend",   irq_pend, 8'h80);
        nmi_in = 1'b1; tick(1);
        nmi_in = 1'b0; tick(1);
        chk("t6_nmi",    vt_no, 1);
        rst_n = 1'b0; #2;
        chk("t6_rintr",  cpu_intr, 0);
        chk("t6_rvt",    vt_no, 0);
        chk("t6_rpend",  irq_pend, 0);
        chk("t6_rnest",  nest_cnt, 0);
        tick(1);
        rst_n = 1'b1; i_bit = 1'b0;
        tick(3);
        chk("t6_lost",   cpu_intr, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
